// File: rtl/data_mem_lsu.sv
// Load/store initiator for the 256x8 big-endian data RAM (MEM stage).
// Optional LSU_ALIGN_CHECK_EN: misaligned half/word accesses fault instead of reaching the RAM.
module data_mem_lsu #(
    parameter int unsigned MEM_DEPTH   = 256,
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_fault,
    output logic        ram_enable,
    output logic        ram_rw,
    output logic [31:0] ram_addr,
    output logic [31:0] ram_wdata,
    output logic [1:0]  ram_size,
    input  logic [31:0] ram_rdata
);

    localparam int unsigned CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             signed_q, signed_d;

    logic        req_ready_d, rsp_valid_d, rsp_fault_d, ram_enable_d, ram_rw_d;
    logic [31:0] rsp_rdata_d, ram_addr_d, ram_wdata_d;
    logic [1:0]  ram_size_d;

    logic [2:0]  nbytes_c;
    logic        range_fault_c, size_fault_c, align_fault_c, fault_c;
    logic [31:0] wdata_mask_c, load_ext_c;

    // Request decode: byte count, fault checks and store-data masking
    always_comb begin
        nbytes_c     = 3'd4;
        wdata_mask_c = req_wdata;
        case (req_size)
            2'b00: begin
                nbytes_c     = 3'd1;
                wdata_mask_c = {24'd0, req_wdata[7:0]};
            end
            2'b01: begin
                nbytes_c     = 3'd2;
                wdata_mask_c = {16'd0, req_wdata[15:0]};
            end
            default: begin
                nbytes_c     = 3'd4;
                wdata_mask_c = req_wdata;
            end
        endcase
    end

    // 33-bit sum so addresses near 2^32 cannot wrap into range
    assign range_fault_c = (({1'b0, req_addr} + 33'(nbytes_c) - 33'd1) > 33'(MEM_DEPTH - 1));
    assign size_fault_c  = (req_size == 2'b11);

`ifdef LSU_ALIGN_CHECK_EN
    assign align_fault_c = ((req_size == 2'b01) && req_addr[0]) ||
                           ((req_size == 2'b10) && (req_addr[1:0] != 2'b00));
`else
    assign align_fault_c = 1'b0;
`endif

    assign fault_c = range_fault_c || size_fault_c || align_fault_c;

    // Load extension of the RAM's right-justified read data
    always_comb begin
        case (ram_size)
            2'b00:   load_ext_c = {{24{signed_q & ram_rdata[7]}}, ram_rdata[7:0]};
            2'b01:   load_ext_c = {{16{signed_q & ram_rdata[15]}}, ram_rdata[15:0]};
            default: load_ext_c = ram_rdata;
        endcase
    end

    // Next-state and next-output logic
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        signed_d     = signed_q;
        req_ready_d  = 1'b0;
        rsp_valid_d  = 1'b0;
        rsp_fault_d  = 1'b0;
        rsp_rdata_d  = 32'd0;
        ram_enable_d = 1'b0;
        ram_rw_d     = ram_rw;
        ram_addr_d   = ram_addr;
        ram_wdata_d  = ram_wdata;
        ram_size_d   = ram_size;

        case (state_q)
            IDLE: begin
                if (req_valid && req_ready) begin
                    ram_rw_d    = req_write;
                    ram_addr_d  = req_addr;
                    ram_size_d  = req_size;
                    ram_wdata_d = wdata_mask_c;
                    signed_d    = req_signed;
                    if (fault_c) begin
                        state_d     = RESP;
                        rsp_valid_d = 1'b1;
                        rsp_fault_d = 1'b1;
                    end else begin
                        state_d = SETUP;
                    end
                end else begin
                    req_ready_d = 1'b1;
                end
            end
            SETUP: begin
                state_d      = ACCESS;
                ram_enable_d = 1'b1;
                cnt_d        = CNT_W'(WAIT_CYCLES - 1);
            end
            ACCESS: begin
                if (cnt_q == '0) begin
                    state_d     = RESP;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = ram_rw ? 32'd0 : load_ext_c;
                end else begin
                    cnt_d        = CNT_W'(cnt_q - 1'b1);
                    ram_enable_d = 1'b1;
                end
            end
            RESP: begin
                state_d     = IDLE;
                req_ready_d = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and registered outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            signed_q   <= 1'b0;
            req_ready  <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_fault  <= 1'b0;
            rsp_rdata  <= 32'd0;
            ram_enable <= 1'b0;
            ram_rw     <= 1'b0;
            ram_addr   <= 32'd0;
            ram_wdata  <= 32'd0;
            ram_size   <= 2'd0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            signed_q   <= signed_d;
            req_ready  <= req_ready_d;
            rsp_valid  <= rsp_valid_d;
            rsp_fault  <= rsp_fault_d;
            rsp_rdata  <= rsp_rdata_d;
            ram_enable <= ram_enable_d;
            ram_rw     <= ram_rw_d;
            ram_addr   <= ram_addr_d;
            ram_wdata  <= ram_wdata_d;
            ram_size   <= ram_size_d;
        end
    end

endmodule
